// File: rtl/vec_mul_pkg.sv
// Shared types and default sizes for the vector-multiplier sequencer.
// Imported by the sequencer top and its address generators.
package vec_mul_pkg;

  localparam int DEF_ADDRESSSIZE   = 10;
  localparam int DEF_MATRIX_SIZE   = 64;
  localparam int DEF_DRAIN_TIMEOUT = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_W,
    S_POP,
    S_RELOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/vec_mul_addr_gen.sv
// Base-plus-counter address generator with clear, enable and
// terminal count; the base is captured on clear.
module vec_mul_addr_gen
  import vec_mul_pkg::*;
#(
  parameter int AW    = DEF_ADDRESSSIZE,
  parameter int CW    = 7,
  parameter int LIMIT = DEF_MATRIX_SIZE
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic [AW-1:0] i_base,
  input  logic          i_en,
  output logic [AW-1:0] o_addr,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [AW-1:0] r_base;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_base <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_base <= i_base;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Modulo-2^AW sum; wrap-around is intentional
  assign o_addr = r_base + AW'(r_cnt);
  assign o_cnt  = r_cnt;
  assign o_tc   = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// Pass sequencer: weight pop/reload, input-row streaming and
// result write-back counting with a drain timeout.
module vec_mul_seq_ctrl
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE   = DEF_ADDRESSSIZE,
  parameter int MATRIX_SIZE   = DEF_MATRIX_SIZE,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE-1:0] result_base_addr,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic                   valid_address,
  output logic [ADDRESSSIZE-1:0] sram_address,
  input  logic                   result_valid,
  output logic                   result_write_enable,
  output logic [ADDRESSSIZE-1:0] result_address,
  output logic                   busy,
  output logic                   end_,
  output logic                   error
);

  localparam int CW = $clog2(MATRIX_SIZE) + 1;
  localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;

  state_e r_state, w_next;

  logic                   r_fre, r_wrl, r_va, r_busy, r_end, r_err;
  logic [ADDRESSSIZE-1:0] r_sram;
  logic [TW-1:0]          r_to;

  logic                   w_accept, w_in_res, w_wr;
  logic                   w_res_last, w_res_done, w_to, w_err_set;
  logic                   w_row_en, w_row_tc, w_res_tc;
  logic [ADDRESSSIZE-1:0] w_row_addr, w_res_addr;
  logic [CW-1:0]          w_res_cnt, w_row_cnt_unused;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_in_res   = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_wr       = result_valid && w_in_res && !w_res_tc;
  assign w_res_last = w_wr && (w_res_cnt == CW'(MATRIX_SIZE - 1));
  assign w_res_done = w_res_tc || w_res_last;
  assign w_to       = (r_to == TW'(DRAIN_TIMEOUT - 1));
  assign w_row_en   = (r_state == S_RELOAD) ||
                      ((r_state == S_STREAM) && !w_row_tc);

  // A last result landing on the timeout cycle wins over the timeout
  assign w_err_set  = (result_valid && !w_wr) ||
                      ((r_state == S_DRAIN) && !w_res_done && w_to);

  vec_mul_addr_gen #(
    .AW    (ADDRESSSIZE),
    .CW    (CW),
    .LIMIT (MATRIX_SIZE)
  ) u_row_gen (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_accept),
    .i_base (base_addr),
    .i_en   (w_row_en),
    .o_addr (w_row_addr),
    .o_cnt  (w_row_cnt_unused),
    .o_tc   (w_row_tc)
  );

  vec_mul_addr_gen #(
    .AW    (ADDRESSSIZE),
    .CW    (CW),
    .LIMIT (MATRIX_SIZE)
  ) u_res_gen (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_accept),
    .i_base (result_base_addr),
    .i_en   (w_wr),
    .o_addr (w_res_addr),
    .o_cnt  (w_res_cnt),
    .o_tc   (w_res_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_WAIT_W;
      S_WAIT_W: if (!fifo_empty) w_next = S_POP;
      S_POP:    w_next = S_RELOAD;
      S_RELOAD: w_next = S_STREAM;
      S_STREAM: if (w_row_tc) w_next = S_DRAIN;
      S_DRAIN:  if (w_res_done || w_to) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fre  <= 1'b0;
      r_wrl  <= 1'b0;
      r_va   <= 1'b0;
      r_busy <= 1'b0;
      r_end  <= 1'b0;
      r_err  <= 1'b0;
      r_sram <= '0;
      r_to   <= '0;
    end else begin
      r_fre  <= (w_next == S_POP);
      r_wrl  <= (w_next == S_RELOAD);
      r_va   <= (w_next == S_STREAM);
      r_busy <= (w_next != S_IDLE);
      r_end  <= (w_next == S_DONE);
      r_err  <= w_err_set || (r_err && !w_accept);
      if (w_row_en) r_sram <= w_row_addr;
      if (r_state == S_DRAIN) r_to <= r_to + 1'b1;
      else                    r_to <= '0;
    end
  end

  assign fifo_read_enable    = r_fre;
  assign weight_reload       = r_wrl;
  assign valid_address       = r_va;
  assign sram_address        = r_sram;
  assign result_write_enable = w_wr;
  assign result_address      = w_res_addr;
  assign busy                = r_busy;
  assign end_                = r_end;
  assign error               = r_err;

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// Directed bench for vec_mul_seq_ctrl: cycle-indexed expectations
// for nominal, FIFO stall, wrap, timeout, stray result and reset.
module tb_vec_mul_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [9:0] base_addr;
  logic [9:0] result_base_addr;
  logic       fifo_empty;
  logic       fifo_read_enable;
  logic       weight_reload;
  logic       valid_address;
  logic [9:0] sram_address;
  logic       result_valid;
  logic       result_write_enable;
  logic [9:0] result_address;
  logic       busy;
  logic       end_;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;

  vec_mul_seq_ctrl dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .base_addr           (base_addr),
    .result_base_addr    (result_base_addr),
    .fifo_empty          (fifo_empty),
    .fifo_read_enable    (fifo_read_enable),
    .weight_reload       (weight_reload),
    .valid_address       (valid_address),
    .sram_address        (sram_address),
    .result_valid        (result_valid),
    .result_write_enable (result_write_enable),
    .result_address      (result_address),
    .busy                (busy),
    .end_                (end_),
    .error               (error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {fifo_read_enable, weight_reload, valid_address,
            busy, end_, error, result_write_enable};
  endfunction

  // One pass started at edge 0. d: cycle fifo_empty drops,
  // r/n: first result cycle and count, s: stray start cycle,
  // rst_at: cycle where reset is asserted (-1 none).
  task automatic run_pass(input int base, input int rb, input int d,
                          input int r, input int n, input int s,
                          input int rst_at);
    int p, e, lo, hi;
    bit to;
    logic [6:0] exp_ctl;
    p  = d + 1;
    to = (n < 64);
    if (to) e = p + 322;
    else e = (r + 64 > p + 67) ? r + 64 : p + 67;
    base_addr        = 10'(base);
    result_base_addr = 10'(rb);
    fifo_empty       = (d > 0);
    start            = 1'b1;
    @(posedge clk); #1;
    start            = 1'b0;
    base_addr        = ~10'(base);
    result_base_addr = ~10'(rb);
    for (int c = 0; c <= e + 2; c++) begin
      fifo_empty   = (c < d);
      result_valid = (c >= r) && (c < r + n);
      start        = (c == s);
      if (c == rst_at) begin
        rstn = 1'b0;
        #1;
        chk($sformatf("rst ctl c=%0d", c), 32'(ctl_vec()), 32'd0);
        chk("rst sram_address", 32'(sram_address), 32'd0);
        chk("rst result_address", 32'(result_address), 32'd0);
        @(negedge clk);
        rstn         = 1'b1;
        result_valid = 1'b0;
        start        = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      exp_ctl = {c == p, c == p + 1, (c >= p + 2) && (c <= p + 65),
                 c <= e, c == e, to && (c >= e), result_valid};
      chk($sformatf("ctl c=%0d", c), 32'(ctl_vec()), 32'(exp_ctl));
      lo = p + 2;
      hi = p + 65;
      if (c >= lo && c <= hi)
        chk($sformatf("sram_address c=%0d", c), 32'(sram_address),
            32'((base + c - lo) % 1024));
      else if (c > hi)
        chk($sformatf("sram_hold c=%0d", c), 32'(sram_address),
            32'((base + 63) % 1024));
      if (result_valid)
        chk($sformatf("result_address c=%0d", c), 32'(result_address),
            32'((rb + c - r) % 1024));
      @(posedge clk); #1;
    end
    result_valid = 1'b0;
    start        = 1'b0;
    fifo_empty   = 1'b0;
  endtask

  initial begin
    rstn             = 1'b0;
    start            = 1'b0;
    base_addr        = '0;
    result_base_addr = '0;
    fifo_empty       = 1'b0;
    result_valid     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", 32'(ctl_vec()), 32'd0);
    chk("reset sram_address", 32'(sram_address), 32'd0);
    chk("reset result_address", 32'(result_address), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Nominal pass
    run_pass(0, 0, 0, 10, 64, -1, -1);
    // FIFO empty until cycle 20
    run_pass(5, 100, 20, 30, 64, -1, -1);
    // Input and result address wrap
    run_pass(1000, 1020, 0, 3, 64, -1, -1);
    // Short of results: drain timeout
    run_pass(0, 0, 0, 10, 60, -1, -1);
    @(negedge clk);
    chk("idle error sticky", 32'(error), 32'd1);
    @(posedge clk); #1;
    // Next start clears error
    run_pass(7, 9, 0, 10, 64, -1, -1);

    // Stray result in IDLE
    result_valid = 1'b1;
    @(negedge clk);
    chk("idle rwe", 32'(result_write_enable), 32'd0);
    @(posedge clk); #1;
    result_valid = 1'b0;
    @(negedge clk);
    chk("idle stray error", 32'(error), 32'd1);
    chk("idle busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    // Start pulse during STREAM is ignored
    run_pass(0, 0, 0, 10, 64, 20, -1);

    // Reset at row 30, then a clean pass
    run_pass(0, 0, 0, 10, 64, -1, 33);
    @(negedge clk);
    chk("post-rst ctl", 32'(ctl_vec()), 32'd0);
    @(posedge clk); #1;
    run_pass(0, 0, 0, 10, 64, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
